// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - UART receive framer: 16x oversampled 8-data, 1-parity, 1-stop receiver
// Optional build macro: UART_RX_MAJORITY_EN selects a 2-of-3 vote over samples 7/8/9 for every bit.
// When the macro is undefined, each bit is a single sample taken at scnt==8.
module uart_rx_frame #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Rx_EN,
  input  logic       RxD,
  output logic [7:0] data,
  output logic       Rx_valid,
  output logic       Rx_PERROR,
  output logic       Rx_FERROR
);

  localparam int DIV = CLK_FREQ / (BAUD_RATE * 16);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

`ifdef UART_RX_MAJORITY_EN
  // The vote needs sample 9, so every bit decision moves one tick later.
  localparam logic [3:0] SAMP = 4'd9;
`else
  localparam logic [3:0] SAMP = 4'd8;
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t        state;
  state_t        state_next;
  logic          rxd_m;
  logic          rxd_s;
  logic [DW-1:0] div_cnt;
  logic          tick;
  logic [3:0]    scnt;
  logic [3:0]    scnt_next;
  logic [2:0]    bit_idx;
  logic [2:0]    idx_next;
  logic [7:0]    shift;
  logic          pbit;
  logic          line_seen_high;
  logic          shift_en;
  logic          pbit_en;
  logic          done;
  logic          bit_val;

`ifdef UART_RX_MAJORITY_EN
  logic samp7;
  logic samp8;

  // Hold the two earlier samples of the current bit for the vote at scnt==9.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      samp7 <= 1'b0;
      samp8 <= 1'b0;
    end else if (tick && state != IDLE) begin
      if (scnt == 4'd7) samp7 <= rxd_s;
      if (scnt == 4'd8) samp8 <= rxd_s;
    end
  end

  assign bit_val = (samp7 & samp8) | (samp7 & rxd_s) | (samp8 & rxd_s);
`else
  assign bit_val = rxd_s;
`endif

  // Two-flop synchronizer for the asynchronous serial line; idles high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= RxD;
      rxd_s <= rxd_m;
    end
  end

  // Oversample tick divider; frozen at zero while the receiver is disabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (!Rx_EN) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  assign tick = Rx_EN && (div_cnt == DIV_LAST);

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, sample-counter and datapath strobes; everything advances on tick.
  always_comb begin
    state_next = state;
    scnt_next  = scnt;
    idx_next   = bit_idx;
    shift_en   = 1'b0;
    pbit_en    = 1'b0;
    done       = 1'b0;
    if (!Rx_EN) begin
      state_next = IDLE;
      scnt_next  = 4'd0;
      idx_next   = 3'd0;
    end else if (tick) begin
      case (state)
        IDLE: begin
          if (line_seen_high && !rxd_s) begin
            state_next = START;
            scnt_next  = 4'd0;
          end
        end
        START: begin
          if (scnt == SAMP && bit_val) begin
            state_next = IDLE;
            scnt_next  = 4'd0;
          end else if (scnt == 4'd15) begin
            state_next = DATA;
            scnt_next  = 4'd0;
            idx_next   = 3'd0;
          end else begin
            scnt_next = scnt + 4'd1;
          end
        end
        DATA: begin
          shift_en = (scnt == SAMP);
          if (scnt == 4'd15) begin
            scnt_next = 4'd0;
            if (bit_idx == 3'd7) begin
              state_next = PARITY;
            end else begin
              idx_next = bit_idx + 3'd1;
            end
          end else begin
            scnt_next = scnt + 4'd1;
          end
        end
        PARITY: begin
          pbit_en = (scnt == SAMP);
          if (scnt == 4'd15) begin
            state_next = STOP;
            scnt_next  = 4'd0;
          end else begin
            scnt_next = scnt + 4'd1;
          end
        end
        STOP: begin
          // Leave mid stop bit so a back-to-back start edge is not missed.
          if (scnt == SAMP) begin
            done       = 1'b1;
            state_next = IDLE;
            scnt_next  = 4'd0;
          end else begin
            scnt_next = scnt + 4'd1;
          end
        end
        default: begin
          state_next = IDLE;
          scnt_next  = 4'd0;
          idx_next   = 3'd0;
        end
      endcase
    end
  end

  // Sample and bit-index counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scnt    <= 4'd0;
      bit_idx <= 3'd0;
    end else begin
      scnt    <= scnt_next;
      bit_idx <= idx_next;
    end
  end

  // Arm start detection only after the line has been seen idle-high, so a break cannot retrigger.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_seen_high <= 1'b1;
    end else if (!Rx_EN) begin
      line_seen_high <= 1'b0;
    end else if (state != IDLE && state_next == IDLE) begin
      line_seen_high <= 1'b0;
    end else if (state == IDLE && rxd_s) begin
      line_seen_high <= 1'b1;
    end
  end

  // Data shift register (LSB arrives first) and captured parity bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift <= 8'h00;
      pbit  <= 1'b0;
    end else begin
      if (shift_en) shift <= {bit_val, shift[7:1]};
      if (pbit_en)  pbit  <= bit_val;
    end
  end

  // Completion: all four outputs update together in the clock after the stop sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data      <= 8'h00;
      Rx_valid  <= 1'b0;
      Rx_PERROR <= 1'b0;
      Rx_FERROR <= 1'b0;
    end else begin
      Rx_valid <= done;
      if (done) begin
        data      <= shift;
        Rx_PERROR <= (^shift) ^ pbit ^ PARITY_ODD;
        Rx_FERROR <= ~bit_val;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb/tb_uart_rx_frame.sv - directed scoreboard bench for uart_rx_frame
module tb_uart_rx_frame;

  localparam int BIT_CLK = 160;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       Rx_EN;
  logic       RxD;
  logic [7:0] data;
  logic       Rx_valid;
  logic       Rx_PERROR;
  logic       Rx_FERROR;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_valid = 0;
  int   n_exp = 0;
  int   ph = 0;
  logic valid_d = 1'b0;
  exp_t exp_q[$];

  uart_rx_frame #(
    .CLK_FREQ  (1_600_000),
    .BAUD_RATE (10_000),
    .PARITY_ODD(1'b0)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .Rx_EN    (Rx_EN),
    .RxD      (RxD),
    .data     (data),
    .Rx_valid (Rx_valid),
    .Rx_PERROR(Rx_PERROR),
    .Rx_FERROR(Rx_FERROR)
  );

  always #5 clk = ~clk;

  // Phase of the 16x tick grid, used only to place stimulus edges.
  always @(posedge clk) begin
    if (reset || !Rx_EN) ph <= 0;
    else ph <= (ph == 9) ? 0 : ph + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard consumer: every Rx_valid pulse pops one expected frame.
  always @(negedge clk) begin
    if (Rx_valid) begin
      exp_t e;
      n_valid++;
      check("valid_width", 32'(valid_d), 32'd0);
      check("unexpected_valid", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("data", 32'(data), 32'(e.d));
        check("perror", 32'(Rx_PERROR), 32'(e.pe));
        check("ferror", 32'(Rx_FERROR), 32'(e.fe));
      end
    end
    valid_d <= Rx_valid;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic align();
    int guard;
    guard = 0;
    do begin
      @(posedge clk);
      #1;
      guard++;
    end while (ph != 7 && guard < 20);
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic pe, input logic fe);
    exp_t e;
    e.d  = d;
    e.pe = pe;
    e.fe = fe;
    exp_q.push_back(e);
    n_exp++;
  endtask

  task automatic drive_bit(input logic v, input logic gl);
    RxD = v;
    if (gl) begin
      wait_clks(88);
      RxD = ~v;
      wait_clks(10);
      RxD = v;
      wait_clks(62);
    end else begin
      wait_clks(BIT_CLK);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pb, input logic sb, input int gk);
    align();
    drive_bit(1'b0, gk == 0);
    for (int i = 0; i < 8; i++) drive_bit(d[i], gk == i + 1);
    drive_bit(pb, gk == 9);
    drive_bit(sb, gk == 10);
  endtask

  initial begin
    logic [7:0] ab;
    reset = 1'b1;
    Rx_EN = 1'b1;
    RxD   = 1'b1;
    wait_clks(5);
    check("reset_data", 32'(data), 32'h00);
    check("reset_valid", 32'(Rx_valid), 32'd0);
    check("reset_perror", 32'(Rx_PERROR), 32'd0);
    check("reset_ferror", 32'(Rx_FERROR), 32'd0);
    reset = 1'b0;
    wait_clks(50);
    check("idle_no_valid", 32'(n_valid), 32'd0);

    expect_frame(8'hA5, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b0, 1'b1, -1);
    check("pending_a5", 32'(exp_q.size()), 32'd0);
    wait_clks(40);

    expect_frame(8'h01, 1'b1, 1'b0);
    send_frame(8'h01, 1'b0, 1'b1, -1);
    check("pending_01", 32'(exp_q.size()), 32'd0);

    expect_frame(8'h3C, 1'b0, 1'b1);
    send_frame(8'h3C, 1'b0, 1'b0, -1);
    wait_clks(2 * 11 * BIT_CLK);
    check("break_one_pulse", 32'(n_valid), 32'(n_exp));
    check("break_ferror_hold", 32'(Rx_FERROR), 32'd1);
    RxD = 1'b1;
    wait_clks(2 * BIT_CLK);
    check("break_line_high_quiet", 32'(n_valid), 32'(n_exp));
    expect_frame(8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b1, -1);
    check("pending_3c", 32'(exp_q.size()), 32'd0);

    align();
    RxD = 1'b0;
    wait_clks(40);
    RxD = 1'b1;
    wait_clks(400);
    check("false_start_no_valid", 32'(n_valid), 32'(n_exp));
    check("false_start_data_hold", 32'(data), 32'h3C);
    check("false_start_ferror_hold", 32'(Rx_FERROR), 32'd0);
    expect_frame(8'h55, 1'b0, 1'b0);
    send_frame(8'h55, 1'b0, 1'b1, -1);
    check("pending_55a", 32'(exp_q.size()), 32'd0);

    ab = 8'h55;
    align();
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(ab[i], 1'b0);
    RxD = ab[4];
    wait_clks(40);
    Rx_EN = 1'b0;
    wait_clks(200);
    Rx_EN = 1'b1;
    RxD = 1'b1;
    wait_clks(400);
    check("abort_no_valid", 32'(n_valid), 32'(n_exp));
    check("abort_data_hold", 32'(data), 32'h55);
    expect_frame(8'h55, 1'b0, 1'b0);
    send_frame(8'h55, 1'b0, 1'b1, -1);
    check("pending_55b", 32'(exp_q.size()), 32'd0);

`ifdef UART_RX_MAJORITY_EN
    expect_frame(8'h00, 1'b0, 1'b0);
`else
    expect_frame(8'h08, 1'b1, 1'b0);
`endif
    send_frame(8'h00, 1'b0, 1'b1, 4);
    check("pending_glitch", 32'(exp_q.size()), 32'd0);

    align();
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    RxD = 1'b1;
    reset = 1'b1;
    wait_clks(2);
    reset = 1'b0;
    wait_clks(2000);
    check("midreset_data", 32'(data), 32'h00);
    check("midreset_perror", 32'(Rx_PERROR), 32'd0);
    check("midreset_ferror", 32'(Rx_FERROR), 32'd0);
    check("midreset_no_valid", 32'(n_valid), 32'(n_exp));

    check("total_pulses", 32'(n_valid), 32'd7);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
